mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer for the LC-3 16-bit × 64K word unified memory. It lets the instruction-fetch path and the load/store data path share the single-port memory. It grants one requester at a time and drives the memory address, write data and write-enable for a fixed, parameterised access window. It then returns read data with a one-cycle acknowledge. It sits between the control unit's fetch/MAR-MDR logic and the memory array.

## Interface
- `WAIT_CYCLES`, 2: cycles the granted address is held on the memory before completion; legal range 1–15.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  synchronous, active-low reset (sampled on rising edge of `clk`).
- `fetch_req`  input  1  fetch read request; held high until `fetch_ack`.
- `fetch_addr`  input  16  fetch word address.
- `fetch_rdata`  output  16  fetch read data; valid in the `fetch_ack` cycle and held until the next fetch completion.
- `fetch_ack`  output  1  one-cycle completion pulse for fetch.
- `data_req`  input  1  data request; held high until `data_ack`.
- `data_we`  input  1  1 = write, 0 = read; sampled at grant.
- `data_addr`  input  16  data word address.
- `data_wdata`  input  16  data write value.
- `data_rdata`  output  16  data read data; valid in the `data_ack` cycle and held until the next data completion.
- `data_ack`  output  1  one-cycle completion pulse for data (reads and writes).
- `mem_addr`  output  16  address to memory.
- `mem_wdata`  output  16  write data to memory.
- `mem_we`  output  1  memory write-enable.
- `mem_rdata`  input  16  combinational memory read data for `mem_addr`.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any request is high, arbitrate (see Configuration).
  - Latch the winner's address, write flag and write data (write flag and write data are forced to 0 for fetch).
  - Record the winner in `last_grant`, load `cnt = WAIT_CYCLES-1`, and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS:**
  - `mem_addr` and `mem_wdata` are driven from the latched values.
  - Each cycle, `cnt` decrements.
  - When `cnt == 0`, `mem_we` = latched write flag for that cycle only. `mem_rdata` is captured into the winner's rdata register, except for writes, where rdata is unchanged. The FSM then goes to RESP.
- **RESP:** the winner's ack = 1 for exactly one cycle, then go to IDLE. Requester inputs are ignored during ACCESS and RESP.
- **Input stability:** a requester must keep address, `data_we` and `data_wdata` stable only until grant. Later changes have no effect.
- **Request deassertion:** a requester must drop its req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- **Address width:** addresses are full 16-bit. There is no wrap or bounds logic, and 0xFFFF is a legal address.
- **`mem_addr` hold:** `mem_addr` holds its last value in IDLE and RESP.
- **Reset (`reset == 0`):**
  - State = IDLE, `cnt` = 0, `last_grant` = fetch.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Both acks = 0, both rdata = 0, `busy` = 0.
- **Reset mid-access:** aborts the access. No `mem_we` pulse and no ack are produced for the aborted request.

## Timing
- Request high and sampled in IDLE at edge N → ACCESS for cycles N+1 … N+WAIT_CYCLES → ack high in cycle N+WAIT_CYCLES+1.
- `mem_we` is high only in cycle N+WAIT_CYCLES.
- Back-to-back throughput is one access per WAIT_CYCLES+2 cycles (IDLE, ACCESS×WAIT_CYCLES, RESP).
- Acks never overlap. At most one of `fetch_ack` / `data_ack` is high in any cycle.
- `mem_we` is never high outside ACCESS.
- All outputs are registered, except `busy`, which decodes the state register.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin arbitration. On a simultaneous request in IDLE, the port not equal to `last_grant` wins. A single request always wins.
- **`MEM_ARB_RR_EN` undefined:** fixed priority, data over fetch. `last_grant` is still updated but is not used.

## Test plan
- **Single fetch, WAIT_CYCLES = 2:**
  - Stimulus: memory word 0x3000 = 0x1234; raise `fetch_req` with `fetch_addr` = 0x3000 at edge 0.
  - Required: `mem_addr` = 0x3000 in cycles 1–2; `fetch_ack` only in cycle 3; `fetch_rdata` = 0x1234 held after; `mem_we` never high.
- **Data write then read:**
  - Stimulus: write 0xBEEF to 0xFFFF, then read 0xFFFF.
  - Required: one `mem_we` pulse in the last ACCESS cycle with `mem_wdata` = 0xBEEF; `data_ack` for the write; the read returns 0xBEEF.
- **Simultaneous requests:**
  - Stimulus: both requests high at reset release, each re-raised after its ack.
  - Required with `MEM_ARB_RR_EN`: grants alternate data, fetch, data, …
  - Required without it: data wins every contested arbitration.
- **Reset mid-access:**
  - Stimulus: assert `reset` = 0 in the first ACCESS cycle of a write.
  - Required: no `mem_we` pulse, no ack; all outputs return to their reset values the next cycle.
- **WAIT_CYCLES = 1 and 15:**
  - Stimulus: single fetch at each setting.
  - Required: ack latency is 2 and 16 cycles respectively; `busy` is high for exactly WAIT_CYCLES+1 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and fixed-window access sequencer for a single-port 64K x 16 memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic [15:0] fetch_rdata,
    output logic        fetch_ack,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic [15:0] data_rdata,
    output logic        data_ack,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_LOAD    = 4'(WAIT_CYCLES - 1);
    localparam logic       GRANT_FETCH = 1'b0;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        last_grant_reg, last_grant_next;
    logic        grant_data_reg, grant_data_next;
    logic        lat_we_reg, lat_we_next;
    logic [15:0] mem_addr_reg, mem_addr_next;
    logic [15:0] mem_wdata_reg, mem_wdata_next;
    logic        mem_we_reg, mem_we_next;
    logic        fetch_ack_reg, fetch_ack_next;
    logic        data_ack_reg, data_ack_next;
    logic [15:0] fetch_rdata_reg, fetch_rdata_next;
    logic [15:0] data_rdata_reg, data_rdata_next;
    logic        pick_data;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_data = data_req && (!fetch_req || last_grant_reg == GRANT_FETCH);
`else
        pick_data = data_req;
`endif
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        last_grant_next  = last_grant_reg;
        grant_data_next  = grant_data_reg;
        lat_we_next      = lat_we_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wdata_next   = mem_wdata_reg;
        mem_we_next      = 1'b0;
        fetch_ack_next   = 1'b0;
        data_ack_next    = 1'b0;
        fetch_rdata_next = fetch_rdata_reg;
        data_rdata_next  = data_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (fetch_req || data_req) begin
                    grant_data_next = pick_data;
                    last_grant_next = pick_data;
                    mem_addr_next   = pick_data ? data_addr : fetch_addr;
                    mem_wdata_next  = pick_data ? data_wdata : 16'h0000;
                    lat_we_next     = pick_data & data_we;
                    cnt_next        = CNT_LOAD;
                    state_next      = ACCESS;
                    // a one-cycle window makes the very next cycle the strobe cycle
                    mem_we_next     = (WAIT_CYCLES == 1) ? (pick_data & data_we) : 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    if (grant_data_reg) begin
                        data_ack_next = 1'b1;
                        if (!lat_we_reg) data_rdata_next = mem_rdata;
                    end else begin
                        fetch_ack_next   = 1'b1;
                        fetch_rdata_next = mem_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                    // registered strobe: raise it on entry to the cnt == 0 cycle
                    if (cnt_reg == 4'd1) mem_we_next = lat_we_reg;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            last_grant_reg  <= GRANT_FETCH;
            grant_data_reg  <= 1'b0;
            lat_we_reg      <= 1'b0;
            mem_addr_reg    <= 16'h0000;
            mem_wdata_reg   <= 16'h0000;
            mem_we_reg      <= 1'b0;
            fetch_ack_reg   <= 1'b0;
            data_ack_reg    <= 1'b0;
            fetch_rdata_reg <= 16'h0000;
            data_rdata_reg  <= 16'h0000;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            last_grant_reg  <= last_grant_next;
            grant_data_reg  <= grant_data_next;
            lat_we_reg      <= lat_we_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wdata_reg   <= mem_wdata_next;
            mem_we_reg      <= mem_we_next;
            fetch_ack_reg   <= fetch_ack_next;
            data_ack_reg    <= data_ack_next;
            fetch_rdata_reg <= fetch_rdata_next;
            data_rdata_reg  <= data_rdata_next;
        end
    end

    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_we      = mem_we_reg;
    assign fetch_ack   = fetch_ack_reg;
    assign data_ack    = data_ack_reg;
    assign fetch_rdata = fetch_rdata_reg;
    assign data_rdata  = data_rdata_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random and directed transactions against a
// memory/arbitration reference model; extra instances cover WAIT_CYCLES = 1 and 15.
module tb_mem_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        fetch_req, data_req, data_we;
    logic [15:0] fetch_addr, data_addr, data_wdata;
    logic [15:0] fetch_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        fetch_ack, data_ack, mem_we, busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_f_rd, exp_d_rd;
    logic [15:0] ref_mem [int];
    logic [15:0] pool [6] = '{16'h0000, 16'hFFFF, 16'h3000, 16'h0042, 16'h8001, 16'h7FFE};

    logic [15:0] env_mem [0:65535];
    bit          env_vld [0:65535];

    function automatic logic [15:0] init_word(input logic [15:0] a);
        if (a == 16'h3000) return 16'h1234;
        return (a * 16'h9E37) ^ 16'h5C3A;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    // Memory array seen by the main instance: combinational read, write on the clock edge.
    assign mem_rdata = env_vld[mem_addr] ? env_mem[mem_addr] : init_word(mem_addr);
    always @(posedge clk) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_vld[mem_addr] <= 1'b1;
        end
    end

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata), .fetch_ack(fetch_ack),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic        s1_req, s15_req, s1_ack, s15_ack, s1_we, s15_we, s1_busy, s15_busy, s1_dack, s15_dack;
    logic [15:0] s_addr, s1_rd, s15_rd, s1_drd, s15_drd, s1_ma, s15_ma, s1_wd, s15_wd;

    mem_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset(reset),
        .fetch_req(s1_req), .fetch_addr(s_addr), .fetch_rdata(s1_rd), .fetch_ack(s1_ack),
        .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000), .data_wdata(16'h0000),
        .data_rdata(s1_drd), .data_ack(s1_dack),
        .mem_addr(s1_ma), .mem_wdata(s1_wd), .mem_we(s1_we), .mem_rdata(s1_ma ^ 16'hA5A5), .busy(s1_busy)
    );

    mem_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .reset(reset),
        .fetch_req(s15_req), .fetch_addr(s_addr), .fetch_rdata(s15_rd), .fetch_ack(s15_ack),
        .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000), .data_wdata(16'h0000),
        .data_rdata(s15_drd), .data_ack(s15_dack),
        .mem_addr(s15_ma), .mem_wdata(s15_wd), .mem_we(s15_we), .mem_rdata(s15_ma ^ 16'hA5A5), .busy(s15_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One isolated request from one port; called at a negedge with the arbiter idle.
    task automatic txn(input bit is_data, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        int lat;
        logic [15:0] exp_wd;
        lat = 0;
        exp_wd = is_data ? wdata : 16'h0000;
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr;
        end
        @(posedge clk);
        for (int k = 1; k <= W + 6 && lat == 0; k++) begin
            @(negedge clk);
            if (fetch_ack || data_ack) lat = k;
            else begin
                check("busy_access", busy, 1);
                check("mem_addr", mem_addr, addr);
                check("mem_wdata", mem_wdata, exp_wd);
                check("mem_we", mem_we, (k == W) && is_data && we);
            end
            data_addr = 16'($urandom); data_wdata = 16'($urandom);
            data_we = 1'($urandom); fetch_addr = 16'($urandom);
        end
        check("ack_latency", lat, W + 1);
        if (lat != 0) begin
            check("fetch_ack", fetch_ack, !is_data);
            check("data_ack", data_ack, is_data);
            check("mem_we_resp", mem_we, 0);
            if (is_data && we) ref_mem[int'(addr)] = wdata;
            else if (is_data) exp_d_rd = ref_read(addr);
            else exp_f_rd = ref_read(addr);
            check("rdata_ack", {fetch_rdata, data_rdata}, {exp_f_rd, exp_d_rd});
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("ack_clear", {fetch_ack, data_ack}, 0);
        check("rdata_hold", {fetch_rdata, data_rdata}, {exp_f_rd, exp_d_rd});
        check("mem_content", env_vld[addr] ? env_mem[addr] : init_word(addr), ref_read(addr));
    endtask

    initial begin
        int  cyc, prev_ack, grants, lat1, lat15, b1, b15;
        bit  last_data, exp_data, is_d, we_seen;

        reset = 1'b0; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = 16'h0; data_addr = 16'h0; data_wdata = 16'h0;
        s1_req = 1'b0; s15_req = 1'b0; s_addr = 16'h0;
        exp_f_rd = 16'h0; exp_d_rd = 16'h0;

        repeat (3) @(negedge clk);
        check("rst_busy", {busy, s1_busy, s15_busy}, 0);
        check("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_ack", {fetch_ack, data_ack}, 0);
        check("rst_rdata", {fetch_rdata, data_rdata}, 0);
        reset = 1'b1;
        @(negedge clk);

        txn(1'b0, 1'b0, 16'h3000, 16'h0000);
        check("fetch_3000", fetch_rdata, 16'h1234);
        txn(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        txn(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        check("read_ffff", data_rdata, 16'hBEEF);

        for (int i = 0; i < 24; i++) begin
            is_d = 1'($urandom);
            txn(is_d, is_d & 1'($urandom), pool[$urandom_range(0, 5)], 16'($urandom));
        end

        // Both ports requesting continuously from reset release.
        reset = 1'b0;
        @(negedge clk);
        exp_f_rd = 16'h0; exp_d_rd = 16'h0;
        fetch_req = 1'b1; data_req = 1'b1; data_we = 1'b0;
        fetch_addr = 16'h1000; data_addr = 16'h2000;
        reset = 1'b1;
        last_data = 1'b0; prev_ack = 0; cyc = 0; grants = 0;
        while (grants < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (fetch_ack || data_ack) begin
`ifdef MEM_ARB_RR_EN
                exp_data = !last_data;
`else
                exp_data = 1'b1;
`endif
                check("arb_overlap", fetch_ack & data_ack, 0);
                check("arb_winner", data_ack, exp_data);
                if (grants > 0) check("arb_period", cyc - prev_ack, W + 2);
                if (exp_data) exp_d_rd = ref_read(16'h2000);
                else exp_f_rd = ref_read(16'h1000);
                check("arb_rdata", {fetch_rdata, data_rdata}, {exp_f_rd, exp_d_rd});
                last_data = exp_data;
                prev_ack = cyc;
                grants++;
            end
        end
        check("arb_grants", grants, 6);
        fetch_req = 1'b0; data_req = 1'b0;
        @(negedge clk);

        // Reset during the first access cycle of a write.
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0055; data_wdata = 16'hDEAD;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy, 1);
        reset = 1'b0; data_req = 1'b0;
        @(negedge clk);
        exp_f_rd = 16'h0; exp_d_rd = 16'h0;
        check("abort_rst_busy", busy, 0);
        check("abort_rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        check("abort_rst_rdata", {fetch_rdata, data_rdata}, 0);
        reset = 1'b1;
        we_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            we_seen = we_seen | mem_we | fetch_ack | data_ack;
        end
        check("abort_quiet", we_seen, 0);
        check("abort_mem", env_vld[16'h0055] ? env_mem[16'h0055] : init_word(16'h0055), ref_read(16'h0055));

        // Single fetch on the WAIT_CYCLES = 1 and 15 instances.
        s_addr = 16'h0BAD; s1_req = 1'b1; s15_req = 1'b1;
        lat1 = 0; lat15 = 0; b1 = 0; b15 = 0; we_seen = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (s1_busy) b1++;
            if (s15_busy) b15++;
            we_seen = we_seen | s1_we | s15_we | s1_dack | s15_dack;
            if (s1_ack && lat1 == 0) begin
                lat1 = k; s1_req = 1'b0;
                check("w1_rdata", s1_rd, 16'h0BAD ^ 16'hA5A5);
            end
            if (s15_ack && lat15 == 0) begin
                lat15 = k; s15_req = 1'b0;
                check("w15_rdata", s15_rd, 16'h0BAD ^ 16'hA5A5);
            end
        end
        s1_req = 1'b0; s15_req = 1'b0;
        check("w1_latency", lat1, 2);
        check("w15_latency", lat15, 16);
        check("w1_busy_cycles", b1, 2);
        check("w15_busy_cycles", b15, 16);
        check("w_no_write", we_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
